// File: rtl/pe_mac_sequencer_if.sv
// pe_mac_sequencer_if: operand-in and result-out handshakes of the sequential MAC lane
interface pe_mac_sequencer_if #(
    parameter int A = 8,
    parameter int B = 8,
    parameter int N = 3,
    parameter int O = A + B + 2
);
    logic           i_valid;
    logic           o_ready;
    logic [N*A-1:0] i_mul_a;
    logic [N*B-1:0] i_mul_b;
    logic           o_valid;
    logic           i_ready;
    logic [O-1:0]   o_result;
    logic           o_busy;
    logic           o_sat;
    modport master (output i_valid, i_mul_a, i_mul_b, i_ready,
                    input  o_ready, o_valid, o_result, o_busy, o_sat);
    modport slave  (input  i_valid, i_mul_a, i_mul_b, i_ready,
                    output o_ready, o_valid, o_result, o_busy, o_sat);
endinterface

// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: one shared multiplier walks N lanes to form a dot product; PE_SEQ_SAT_EN enables saturating accumulation
module pe_mac_sequencer #(
    parameter int A = 8,
    parameter int B = 8,
    parameter int N = 3,
    parameter int O = A + B + 2
) (
    input logic               i_clk,
    input logic               i_resetn,
    pe_mac_sequencer_if.slave bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t         state, state_nxt;
    logic [KW-1:0]  k;
    logic [N*A-1:0] op_a;
    logic [N*B-1:0] op_b;
    logic [O-1:0]   acc, acc_nxt;
    logic [A-1:0]   a_k;
    logic [B-1:0]   b_k;
    logic [A+B-1:0] prod;
    logic           last, accept;
    assign accept = (state == IDLE) && bus.i_valid;
    assign last   = (k == KW'(N - 1));
    assign a_k    = op_a[A*int'(k) +: A];
    assign b_k    = op_b[B*int'(k) +: B];
    assign prod   = a_k * b_k;
`ifdef PE_SEQ_SAT_EN
    logic [O:0] sum;
    logic       sat;
    assign sum     = {1'b0, acc} + (O+1)'(prod);
    assign acc_nxt = sum[O] ? '1 : sum[O-1:0];
    assign bus.o_sat = sat;
    // Sticky overflow flag, cleared when a new vector is taken
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) sat <= 1'b0;
        else if (accept) sat <= 1'b0;
        else if (state == MAC) sat <= sat | sum[O];
    end
`else
    assign acc_nxt   = acc + O'(prod);
    assign bus.o_sat = 1'b0;
`endif
    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) state <= IDLE;
        else state <= state_nxt;
    end
    // Next state: take a vector, run N MAC cycles, hold result until collected
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.i_valid ? MAC : IDLE;
            MAC:     state_nxt = last ? DONE : MAC;
            DONE:    state_nxt = bus.i_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // Operand capture, lane walk and accumulation
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            op_a <= '0;
            op_b <= '0;
            acc  <= '0;
            k    <= '0;
        end else if (accept) begin
            op_a <= bus.i_mul_a;
            op_b <= bus.i_mul_b;
            acc  <= '0;
            k    <= '0;
        end else if (state == MAC) begin
            acc <= acc_nxt;
            k   <= last ? '0 : k + KW'(1);
        end
    end
    assign bus.o_ready  = (state == IDLE);
    assign bus.o_valid  = (state == DONE);
    assign bus.o_busy   = (state == MAC);
    assign bus.o_result = acc;
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb_pe_mac_sequencer: directed scoreboard bench for pe_mac_sequencer (N=3 and N=5 instances)
module tb_pe_mac_sequencer;
    logic i_clk = 1'b0;
    logic i_resetn = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [17:0] q[$];
    always #5 i_clk = ~i_clk;
    pe_mac_sequencer_if #(.N(3)) b3();
    pe_mac_sequencer_if #(.N(5)) b5();
    pe_mac_sequencer #(.N(3)) u3 (.i_clk(i_clk), .i_resetn(i_resetn), .bus(b3.slave));
    pe_mac_sequencer #(.N(5)) u5 (.i_clk(i_clk), .i_resetn(i_resetn), .bus(b5.slave));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [17:0] model(input logic [39:0] a, input logic [39:0] b, input int n);
        longint s = 0;
        logic [63:0] r;
        for (int i = 0; i < n; i++) s += longint'(a[i*8 +: 8]) * longint'(b[i*8 +: 8]);
`ifdef PE_SEQ_SAT_EN
        if (s > 262143) s = 262143;
`endif
        r = 64'(s);
        return r[17:0];
    endfunction
    // Scoreboard: push at the accept edge, pop and compare at the collect edge
    always @(negedge i_clk) begin
        if (i_resetn) begin
            if (b3.i_valid && b3.o_ready) q.push_back(model(40'(b3.i_mul_a), 40'(b3.i_mul_b), 3));
            if (b3.o_valid && b3.i_ready) begin
                chk("result_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) chk("result", 32'(b3.o_result), 32'(q.pop_front()));
            end
        end
    end
    task automatic send3(input logic [23:0] a, input logic [23:0] b);
        logic ok = 1'b0;
        @(posedge i_clk); #1;
        b3.i_valid = 1'b1; b3.i_mul_a = a; b3.i_mul_b = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_clk);
            ok = b3.o_ready;
        end
        chk("accept_wait", 32'(ok), 1);
        @(posedge i_clk); #1;
        b3.i_valid = 1'b0;
    endtask
    task automatic wait_valid3(output int cyc);
        cyc = 1;
        for (int n = 0; n < 50 && !b3.o_valid; n++) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        chk("valid_wait", 32'(b3.o_valid), 1);
    endtask
    task automatic count_low(output int cnt);
        logic done = 1'b0;
        cnt = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge i_clk);
            if (b3.o_ready) done = 1'b1;
            else cnt++;
        end
    endtask
    initial begin
        int lat, cnt;
        logic [23:0] ra, rb;
        logic [17:0] e;
        logic ok;
        b3.i_valid = 0; b3.i_mul_a = '0; b3.i_mul_b = '0; b3.i_ready = 1;
        b5.i_valid = 0; b5.i_mul_a = '0; b5.i_mul_b = '0; b5.i_ready = 1;
        #12;
        chk("rst_ready", 32'(b3.o_ready), 1);
        chk("rst_valid", 32'(b3.o_valid), 0);
        chk("rst_result", 32'(b3.o_result), 0);
        chk("rst_busy", 32'(b3.o_busy), 0);
        chk("rst_sat", 32'(b3.o_sat), 0);
        chk("rst_valid_n5", 32'(b5.o_valid), 0);
        @(negedge i_clk); i_resetn = 1'b1;
        @(posedge i_clk); #1;
        chk("idle_ready", 32'(b3.o_ready), 1);
        // Directed vector from the worked example
        send3(24'h301430, 24'h483C48);
        chk("busy_mac", 32'(b3.o_busy), 1);
        chk("ready_mac", 32'(b3.o_ready), 0);
        wait_valid3(lat);
        chk("latency", 32'(lat), 4);
        chk("result_ex", 32'(b3.o_result), 32'h01FB0);
        chk("busy_done", 32'(b3.o_busy), 0);
        chk("sat_n3", 32'(b3.o_sat), 0);
        @(posedge i_clk); #1;
        chk("ready_after_collect", 32'(b3.o_ready), 1);
        // Zeros then all-ones, back to back
        send3(24'h0, 24'h0);
        b3.i_valid = 1'b1; b3.i_mul_a = 24'hFFFFFF; b3.i_mul_b = 24'hFFFFFF;
        count_low(cnt);
        chk("ready_low_zero", 32'(cnt), 4);
        @(posedge i_clk); #1;
        b3.i_valid = 1'b0; b3.i_mul_a = '0; b3.i_mul_b = '0;
        count_low(cnt);
        chk("ready_low_ones", 32'(cnt), 4);
        chk("model_ones", 32'(model(40'hFFFFFF, 40'hFFFFFF, 3)), 32'h2FA03);
        // Back-pressure in DONE
        b3.i_ready = 1'b0;
        ra = 24'($urandom); rb = 24'($urandom);
        e = model(40'(ra), 40'(rb), 3);
        send3(ra, rb);
        wait_valid3(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(b3.o_valid), 1);
            chk("hold_result", 32'(b3.o_result), 32'(e));
            chk("hold_ready", 32'(b3.o_ready), 0);
        end
        @(posedge i_clk); #1;
        b3.i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("release_ready", 32'(b3.o_ready), 1);
        chk("release_valid", 32'(b3.o_valid), 0);
        // Inputs churn while MAC runs
        send3(24'($urandom), 24'($urandom));
        for (int i = 0; i < 3; i++) begin
            b3.i_mul_a = 24'($urandom); b3.i_mul_b = 24'($urandom);
            @(posedge i_clk); #1;
        end
        wait_valid3(lat);
        @(posedge i_clk); #1;
        // Reset mid-MAC at lane 1
        send3(24'h111111, 24'h222222);
        @(posedge i_clk); #1;
        i_resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(b3.o_ready), 1);
        chk("mid_rst_valid", 32'(b3.o_valid), 0);
        chk("mid_rst_busy", 32'(b3.o_busy), 0);
        chk("mid_rst_result", 32'(b3.o_result), 0);
        q.delete();
        repeat (2) @(negedge i_clk);
        i_resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            chk("no_valid_after_rst", 32'(b3.o_valid), 0);
        end
        send3(24'h0A0B0C, 24'h0D0E0F);
        wait_valid3(lat);
        chk("latency_after_rst", 32'(lat), 4);
        chk("result_after_rst", 32'(b3.o_result), 32'(model(40'h0A0B0C, 40'h0D0E0F, 3)));
        @(posedge i_clk); #1;
        // N=5 overflow case
        b5.i_valid = 1'b1; b5.i_mul_a = '1; b5.i_mul_b = '1;
        @(negedge i_clk);
        chk("n5_ready", 32'(b5.o_ready), 1);
        @(posedge i_clk); #1;
        b5.i_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_clk);
            ok = b5.o_valid;
        end
        chk("n5_valid_wait", 32'(ok), 1);
`ifdef PE_SEQ_SAT_EN
        chk("n5_result", 32'(b5.o_result), 32'h3FFFF);
        chk("n5_sat", 32'(b5.o_sat), 1);
`else
        chk("n5_result", 32'(b5.o_result), 32'h0F605);
        chk("n5_sat", 32'(b5.o_sat), 0);
`endif
        repeat (3) @(posedge i_clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
